branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Gshare branch-prediction controller for the pipelined RISC-V core.
- Owns a pattern history table (PHT) of 2-bit saturating counters, a direct-mapped BTB and a global history register (GHR).
- Serves one combinational predict lookup per cycle to IF and accepts one resolved-branch update per cycle from EX.
- Sequences table initialisation after reset and after a flush request.

Parameters:
- PC_WIDTH, 32, instruction address width.
- INDEX_BITS, 5, log2 of the PHT/BTB entry count (32 entries).
- GHR_BITS, 5, global history length. Legal range 1..INDEX_BITS; zero-extended to INDEX_BITS when hashed.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush_tables  input  1  synchronous request to re-initialise the PHT, BTB and GHR.
- busy  output  1  high while the INIT sweep runs.
- pred_pc  input  PC_WIDTH  PC of the instruction in IF.
- pred_taken  output  1  predicted taken.
- pred_target  output  PC_WIDTH  predicted next PC.
- pred_index  output  INDEX_BITS  PHT index used for this prediction; carried down the pipeline.
- upd_valid  input  1  a resolved branch/jump is presented this cycle.
- upd_pc  input  PC_WIDTH  PC of the resolved instruction.
- upd_index  input  INDEX_BITS  pred_index captured at prediction time.
- upd_taken  input  1  actual outcome.
- upd_target  input  PC_WIDTH  actual target.
- upd_mispredict  input  1  EX detected a misprediction.
- stat_branches  output  32  count of accepted updates.
- stat_mispredicts  output  32  count of accepted updates with upd_mispredict=1.

Behaviour:
- FSM states: INIT, RUN.
  - reset asserted (asynchronous) forces state=INIT, sweep pointer=0, GHR=0, both stat counters=0.
  - In INIT, one entry per cycle at pointer p: PHT[p]=2'b01 (weakly not-taken), BTB valid[p]=0. Pointer increments each cycle.
  - After entry 2^INDEX_BITS-1 is written, state becomes RUN on the next edge. The sweep therefore lasts exactly 2^INDEX_BITS cycles after reset deasserts.
  - busy=1 exactly while state=INIT.
  - flush_tables=1 in RUN moves to INIT on the next edge with pointer=0 and GHR=0. Stat counters are not cleared.
  - flush_tables=1 during INIT restarts the sweep at pointer=0.
  - reset asserted mid-INIT restarts the sweep immediately.
- Prediction (combinational, zero latency):
  - pred_index = pred_pc[INDEX_BITS+1:2] XOR zero-extended GHR.
  - BTB lookup is indexed by pred_pc[INDEX_BITS+1:2] and tag-compared against pred_pc[PC_WIDTH-1:INDEX_BITS+2].
  - pred_taken = (state==RUN) AND BTB hit AND PHT[pred_index][1].
  - pred_target = BTB target when pred_taken=1, else pred_pc+4 (wraps modulo 2^PC_WIDTH).
  - In INIT: pred_taken=0 and pred_target=pred_pc+4.
- Update (one edge, accepted only when upd_valid=1 AND state==RUN; ignored in INIT and in the cycle flush_tables=1 is sampled):
  - PHT[upd_index]: taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - If upd_taken=1, the BTB entry at upd_pc[INDEX_BITS+1:2] is written with valid=1, tag, and upd_target. Not-taken updates leave the BTB unchanged.
  - GHR <= {GHR[GHR_BITS-2:0], upd_taken}; for GHR_BITS=1, GHR <= upd_taken.
  - stat_branches += 1; stat_mispredicts += upd_mispredict. Both wrap at 2^32.
- Simultaneous predict and update to the same entry: prediction sees the pre-update value (no bypass). The new value is visible from the next cycle.
- No outputs are registered except busy and the stat counters, which read 0 during and after reset.

Test Plan:
1. Assert reset, release -> busy=1 for exactly 32 cycles, then 0. During the sweep, pred_pc=0x100 gives pred_taken=0, pred_target=0x104. upd_valid pulses during the sweep leave stat_branches=0.
2. After INIT, branch at PC 0x40 to target 0x80: first update upd_taken=1, upd_index=pred_index (GHR=0, index 0x10) -> PHT[0x10]=2. Next lookup of 0x40 with GHR=00001 uses index 0x11; returns pred_taken=0 (PHT=1) and pred_target=0x44.
3. Hold GHR fixed via repeated upd_taken=1 at upd_index=3, five times -> counter saturates at 3. Then three not-taken updates -> 2,1,0. A fourth not-taken update keeps 0.
4. BTB alias: train 0x40->0x80 as taken until PHT=3, then lookup 0x1040 (same BTB index, different tag) -> pred_taken=0, pred_target=0x1044.
5. Pulse flush_tables in RUN after training -> busy=1 for 32 cycles, GHR=0, trained PC predicts not-taken afterwards, stat counters retain their values.
6. Assert reset asynchronously (between clock edges) at sweep pointer 17 -> busy stays 1 and the sweep restarts. Exactly 32 cycles follow reset release before busy=0.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// -----------------------------------------------------------------------------
// branch_predict_ctrl
//
// Gshare branch-prediction controller. Holds a pattern history table (PHT) of
// 2-bit saturating counters, a direct-mapped branch target buffer (BTB) and a
// global history register (GHR). IF gets one combinational lookup per cycle,
// EX returns one resolved branch per cycle. After reset or a flush request the
// tables are swept clean one entry per cycle while busy is high.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   flush_tables      synchronous request to re-initialise PHT, BTB and GHR
//   busy              high while the initialisation sweep runs
//   pred_pc           PC of the instruction in IF
//   pred_taken        predicted taken
//   pred_target       predicted next PC
//   pred_index        PHT index used for the prediction (travels down the pipe)
//   upd_valid         resolved branch/jump presented this cycle
//   upd_pc            PC of the resolved instruction
//   upd_index         pred_index captured at prediction time
//   upd_taken         actual outcome
//   upd_target        actual target
//   upd_mispredict    EX detected a misprediction
//   stat_branches     count of accepted updates (wraps)
//   stat_mispredicts  count of accepted mispredicted updates (wraps)
// -----------------------------------------------------------------------------
module branch_predict_ctrl #(
   parameter int unsigned PC_WIDTH   = 32,
   parameter int unsigned INDEX_BITS = 5,
   parameter int unsigned GHR_BITS   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_tables,
   output logic                  busy,
   input  logic [PC_WIDTH-1:0]   pred_pc,
   output logic                  pred_taken,
   output logic [PC_WIDTH-1:0]   pred_target,
   output logic [INDEX_BITS-1:0] pred_index,
   input  logic                  upd_valid,
   input  logic [PC_WIDTH-1:0]   upd_pc,
   input  logic [INDEX_BITS-1:0] upd_index,
   input  logic                  upd_taken,
   input  logic [PC_WIDTH-1:0]   upd_target,
   input  logic                  upd_mispredict,
   output logic [31:0]           stat_branches,
   output logic [31:0]           stat_mispredicts
);

   localparam int unsigned Entries = 1 << INDEX_BITS;
   localparam int unsigned TagBits = PC_WIDTH - INDEX_BITS - 2;

   typedef enum logic [0:0] {
      StInit,
      StRun
   } state_e;

   // ---------------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------------
   state_e                state_q, state_d;
   logic [INDEX_BITS-1:0] ptr_q, ptr_d;
   logic [GHR_BITS-1:0]   ghr_q, ghr_d;
   logic [31:0]           stat_br_q, stat_br_d;
   logic [31:0]           stat_mis_q, stat_mis_d;

   // ---------------------------------------------------------------------------
   // Tables (no reset: the sweep initialises them)
   // ---------------------------------------------------------------------------
   logic [1:0]          pht_q        [Entries];
   logic                btb_valid_q  [Entries];
   logic [TagBits-1:0]  btb_tag_q    [Entries];
   logic [PC_WIDTH-1:0] btb_target_q [Entries];

   // Single write port per table, selected by the FSM
   logic                  pht_we;
   logic [INDEX_BITS-1:0] pht_waddr;
   logic [1:0]            pht_wdata;
   logic                  btb_we;
   logic [INDEX_BITS-1:0] btb_waddr;
   logic                  btb_wvalid;
   logic [TagBits-1:0]    btb_wtag;
   logic [PC_WIDTH-1:0]   btb_wtarget;

   // ---------------------------------------------------------------------------
   // Prediction path (purely combinational, reads pre-update table contents)
   // ---------------------------------------------------------------------------
   logic [INDEX_BITS-1:0] pred_btb_idx;
   logic [TagBits-1:0]    pred_tag;
   logic [INDEX_BITS-1:0] ghr_ext;
   logic                  btb_hit;
   logic [PC_WIDTH-1:0]   pred_seq_pc;

   always_comb begin
      pred_btb_idx = pred_pc[INDEX_BITS+1:2];
      pred_tag     = pred_pc[PC_WIDTH-1:INDEX_BITS+2];
      ghr_ext      = INDEX_BITS'(ghr_q);
      pred_index   = pred_btb_idx ^ ghr_ext;
      btb_hit      = btb_valid_q[pred_btb_idx] && (btb_tag_q[pred_btb_idx] == pred_tag);
      pred_seq_pc  = pred_pc + PC_WIDTH'(4);
      pred_taken   = (state_q == StRun) && btb_hit && pht_q[pred_index][1];
      pred_target  = pred_taken ? btb_target_q[pred_btb_idx] : pred_seq_pc;
   end

   // ---------------------------------------------------------------------------
   // Update path helpers
   // ---------------------------------------------------------------------------
   logic [1:0] pht_cur;
   logic [1:0] pht_next;

   always_comb begin
      pht_cur  = pht_q[upd_index];
      pht_next = pht_cur;
      if (upd_taken) begin
         if (pht_cur != 2'b11) pht_next = pht_cur + 2'b01;
      end else begin
         if (pht_cur != 2'b00) pht_next = pht_cur - 2'b01;
      end
   end

   // Low PC bits never select a table entry
   logic unused_upd_pc_lsbs;
   assign unused_upd_pc_lsbs = ^upd_pc[1:0];

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      ghr_d       = ghr_q;
      stat_br_d   = stat_br_q;
      stat_mis_d  = stat_mis_q;
      pht_we      = 1'b0;
      pht_waddr   = upd_index;
      pht_wdata   = pht_next;
      btb_we      = 1'b0;
      btb_waddr   = upd_pc[INDEX_BITS+1:2];
      btb_wvalid  = 1'b1;
      btb_wtag    = upd_pc[PC_WIDTH-1:INDEX_BITS+2];
      btb_wtarget = upd_target;

      unique case (state_q)
         StInit: begin
            // Clear one entry per cycle: weakly not-taken, BTB invalid
            pht_we      = 1'b1;
            pht_waddr   = ptr_q;
            pht_wdata   = 2'b01;
            btb_we      = 1'b1;
            btb_waddr   = ptr_q;
            btb_wvalid  = 1'b0;
            btb_wtag    = '0;
            btb_wtarget = '0;
            ptr_d       = ptr_q + 1'b1;
            if (flush_tables) begin
               ptr_d = '0;
            end else if (ptr_q == {INDEX_BITS{1'b1}}) begin
               state_d = StRun;
            end
         end

         StRun: begin
            if (flush_tables) begin
               // Flush wins over a same-cycle update; stats survive
               state_d = StInit;
               ptr_d   = '0;
               ghr_d   = '0;
            end else if (upd_valid) begin
               pht_we     = 1'b1;
               btb_we     = upd_taken;
               // Shift in the outcome; cast keeps the low GHR_BITS bits
               ghr_d      = GHR_BITS'({ghr_q, upd_taken});
               stat_br_d  = stat_br_q + 32'd1;
               stat_mis_d = stat_mis_q + {31'd0, upd_mispredict};
            end
         end

         default: begin
            state_d = StInit;
            ptr_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StInit;
         ptr_q      <= '0;
         ghr_q      <= '0;
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         ghr_q      <= ghr_d;
         stat_br_q  <= stat_br_d;
         stat_mis_q <= stat_mis_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Table storage
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (pht_we) begin
         pht_q[pht_waddr] <= pht_wdata;
      end
      if (btb_we) begin
         btb_valid_q[btb_waddr]  <= btb_wvalid;
         btb_tag_q[btb_waddr]    <= btb_wtag;
         btb_target_q[btb_waddr] <= btb_wtarget;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign busy             = (state_q == StInit);
   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_ctrl
//
// Directed bench for branch_predict_ctrl with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_branch_predict_ctrl;

   logic        clk;
   logic        reset;
   logic        flush_tables;
   logic        busy;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [4:0]  pred_index;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [4:0]  upd_index;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int n_checks;
   int n_pass;
   int exp_br;
   int exp_mis;

   branch_predict_ctrl #(
      .PC_WIDTH   (32),
      .INDEX_BITS (5),
      .GHR_BITS   (5)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .flush_tables     (flush_tables),
      .busy             (busy),
      .pred_pc          (pred_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .pred_index       (pred_index),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_index        (upd_index),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One accepted-or-not update cycle; caller tracks expected stats
   task automatic do_update(input logic [31:0] pc, input logic [4:0] idx, input logic tk,
                            input logic [31:0] tgt, input logic mis);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_index      = idx;
      upd_taken      = tk;
      upd_target     = tgt;
      upd_mispredict = mis;
      @(posedge clk);
      #1;
      upd_valid      = 1'b0;
   endtask

   // Five not-taken updates on a scratch entry (index 0x0A) clear the GHR
   task automatic clear_ghr();
      for (int i = 0; i < 5; i++) begin
         do_update(32'h28, 5'h0A, 1'b0, 32'h0, 1'b0);
         exp_br++;
      end
   endtask

   // Counts rising edges until busy drops, bounded at 100
   task automatic count_busy(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (busy && cycles < 100);
   endtask

   task automatic test_reset();
      int cycles;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
      n_checks++; if (stat_branches !== 32'd0) $display("FAIL reset_stat_br: got %0d want 0", stat_branches); else n_pass++;
      n_checks++; if (stat_mispredicts !== 32'd0) $display("FAIL reset_stat_mis: got %0d want 0", stat_mispredicts); else n_pass++;
      reset   = 1'b0;
      pred_pc = 32'h100;
      cycles  = 0;
      do begin
         if (cycles == 3) upd_valid = 1'b1;
         if (cycles == 6) upd_valid = 1'b0;
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 5) begin
            n_checks++; if (pred_taken !== 1'b0) $display("FAIL init_pred_taken: got %b want 0", pred_taken); else n_pass++;
            n_checks++; if (pred_target !== 32'h104) $display("FAIL init_pred_target: got %h want 104", pred_target); else n_pass++;
         end
      end while (busy && cycles < 100);
      upd_valid = 1'b0;
      n_checks++; if (cycles != 32) $display("FAIL init_busy_cycles: got %0d want 32", cycles); else n_pass++;
      n_checks++; if (stat_branches !== 32'd0) $display("FAIL init_upd_ignored: got %0d want 0", stat_branches); else n_pass++;
   endtask

   task automatic test_first_branch();
      pred_pc = 32'h40;
      #1;
      n_checks++; if (pred_index !== 5'h10) $display("FAIL fb_index0: got %h want 10", pred_index); else n_pass++;
      n_checks++; if (pred_taken !== 1'b0) $display("FAIL fb_taken0: got %b want 0", pred_taken); else n_pass++;
      n_checks++; if (pred_target !== 32'h44) $display("FAIL fb_target0: got %h want 44", pred_target); else n_pass++;
      do_update(32'h40, 5'h10, 1'b1, 32'h80, 1'b1);
      exp_br++; exp_mis++;
      n_checks++; if (pred_index !== 5'h11) $display("FAIL fb_index1: got %h want 11", pred_index); else n_pass++;
      n_checks++; if (pred_taken !== 1'b0) $display("FAIL fb_taken1: got %b want 0", pred_taken); else n_pass++;
      n_checks++; if (pred_target !== 32'h44) $display("FAIL fb_target1: got %h want 44", pred_target); else n_pass++;
      n_checks++; if (stat_branches !== 32'd1) $display("FAIL fb_stat_br: got %0d want 1", stat_branches); else n_pass++;
      n_checks++; if (stat_mispredicts !== 32'd1) $display("FAIL fb_stat_mis: got %0d want 1", stat_mispredicts); else n_pass++;
   endtask

   // Counter at PHT[3] observed through pc 0x0C (BTB index 3) with GHR cleared
   task automatic test_saturation();
      logic exp_tk [6];
      logic step_tk [6];
      exp_tk  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      step_tk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         do_update(32'h0C, 5'h03, 1'b1, 32'h300, 1'b0);
         exp_br++;
      end
      clear_ghr();
      pred_pc = 32'h0C;
      #1;
      n_checks++; if (pred_index !== 5'h03) $display("FAIL sat_index: got %h want 03", pred_index); else n_pass++;
      n_checks++; if (pred_taken !== 1'b1) $display("FAIL sat_taken_hi: got %b want 1", pred_taken); else n_pass++;
      n_checks++; if (pred_target !== 32'h300) $display("FAIL sat_target_hi: got %h want 300", pred_target); else n_pass++;
      for (int s = 0; s < 6; s++) begin
         do_update(32'h0C, 5'h03, step_tk[s], 32'h300, 1'b0);
         exp_br++;
         clear_ghr();
         n_checks++;
         if (pred_taken !== exp_tk[s])
            $display("FAIL sat_step%0d: got %b want %b", s, pred_taken, exp_tk[s]);
         else n_pass++;
      end
   endtask

   task automatic test_btb_alias();
      do_update(32'h40, 5'h10, 1'b1, 32'h80, 1'b0);
      exp_br++;
      clear_ghr();
      pred_pc = 32'h40;
      #1;
      n_checks++; if (pred_taken !== 1'b1) $display("FAIL alias_trained_taken: got %b want 1", pred_taken); else n_pass++;
      n_checks++; if (pred_target !== 32'h80) $display("FAIL alias_trained_target: got %h want 80", pred_target); else n_pass++;
      pred_pc = 32'h1040;
      #1;
      n_checks++; if (pred_index !== 5'h10) $display("FAIL alias_index: got %h want 10", pred_index); else n_pass++;
      n_checks++; if (pred_taken !== 1'b0) $display("FAIL alias_taken: got %b want 0", pred_taken); else n_pass++;
      n_checks++; if (pred_target !== 32'h1044) $display("FAIL alias_target: got %h want 1044", pred_target); else n_pass++;
      n_checks++; if (stat_branches !== 32'(exp_br)) $display("FAIL alias_stat_br: got %0d want %0d", stat_branches, exp_br); else n_pass++;
   endtask

   task automatic test_flush();
      int cycles;
      // GHR=1 beforehand so a missing GHR clear shows up in pred_index
      do_update(32'h0, 5'h0A, 1'b1, 32'h0, 1'b0);
      exp_br++;
      flush_tables = 1'b1;
      do_update(32'h40, 5'h10, 1'b1, 32'h80, 1'b1);
      flush_tables = 1'b0;
      n_checks++; if (busy !== 1'b1) $display("FAIL flush_busy: got %b want 1", busy); else n_pass++;
      count_busy(cycles);
      n_checks++; if (cycles != 32) $display("FAIL flush_busy_cycles: got %0d want 32", cycles); else n_pass++;
      pred_pc = 32'h40;
      #1;
      n_checks++; if (pred_index !== 5'h10) $display("FAIL flush_index: got %h want 10", pred_index); else n_pass++;
      n_checks++; if (pred_taken !== 1'b0) $display("FAIL flush_taken: got %b want 0", pred_taken); else n_pass++;
      n_checks++; if (pred_target !== 32'h44) $display("FAIL flush_target: got %h want 44", pred_target); else n_pass++;
      n_checks++; if (stat_branches !== 32'(exp_br)) $display("FAIL flush_stat_br: got %0d want %0d", stat_branches, exp_br); else n_pass++;
      n_checks++; if (stat_mispredicts !== 32'(exp_mis)) $display("FAIL flush_stat_mis: got %0d want %0d", stat_mispredicts, exp_mis); else n_pass++;
   endtask

   task automatic test_reset_mid_init();
      int cycles;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      repeat (17) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b1) $display("FAIL midreset_busy: got %b want 1", busy); else n_pass++;
      n_checks++; if (stat_branches !== 32'd0) $display("FAIL midreset_stat: got %0d want 0", stat_branches); else n_pass++;
      #1;
      reset = 1'b0;
      count_busy(cycles);
      n_checks++; if (cycles != 32) $display("FAIL midreset_cycles: got %0d want 32", cycles); else n_pass++;
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      exp_br         = 0;
      exp_mis        = 0;
      reset          = 1'b1;
      flush_tables   = 1'b0;
      pred_pc        = '0;
      upd_valid      = 1'b0;
      upd_pc         = '0;
      upd_index      = '0;
      upd_taken      = 1'b0;
      upd_target     = '0;
      upd_mispredict = 1'b0;
      test_reset();
      test_first_branch();
      test_saturation();
      test_btb_alias();
      test_flush();
      test_reset_mid_init();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
